// File: rtl/tile_row_collector.sv
// rtl/tile_row_collector.sv - ping-pong band buffer turning result tiles into a row-major stream
module tile_row_collector #(
    parameter int WIDTH          = 16,
    parameter int BLOCK_SIZE     = 2,
    parameter int CHUNK_SIZE     = 4,
    parameter int ROW_SIZE_MAT_C = 3,
    parameter int COL_SIZE_MAT_C = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tile_valid,
    output logic                          tile_ready,
    input  logic [WIDTH*CHUNK_SIZE-1:0]   tile_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WIDTH*BLOCK_SIZE-1:0]   m_data,
    output logic                          m_last,
    output logic                          done,
    output logic                          overflow
);

    localparam int TW  = WIDTH * CHUNK_SIZE;
    localparam int RW  = WIDTH * BLOCK_SIZE;
    localparam int CW  = (COL_SIZE_MAT_C > 1) ? $clog2(COL_SIZE_MAT_C) : 1;
    localparam int RBW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int BW  = (ROW_SIZE_MAT_C > 1) ? $clog2(ROW_SIZE_MAT_C) : 1;

    localparam logic [CW-1:0]  COL_LAST  = CW'(COL_SIZE_MAT_C - 1);
    localparam logic [RBW-1:0] ROW_LAST  = RBW'(BLOCK_SIZE - 1);
    localparam logic [BW-1:0]  BAND_LAST = BW'(ROW_SIZE_MAT_C - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state, state_next;
    logic [TW-1:0]   tile_buf [2][COL_SIZE_MAT_C];
    logic [1:0]      full;
    logic            wr_bank, rd_bank;
    logic [CW-1:0]   tile_col, beat_c;
    logic [RBW-1:0]  beat_r;
    logic [BW-1:0]   band;
    logic            accept, beat_hs, last_beat;

    assign tile_ready = !full[wr_bank];
    assign accept     = tile_valid && tile_ready;
    assign last_beat  = (beat_r == ROW_LAST) && (beat_c == COL_LAST);

    // Presenting in IDLE as soon as the bank fills gives first m_valid one cycle after the completing tile.
    always_comb begin
        state_next = state;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        beat_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    m_valid    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: m_valid = 1'b1;
            default: state_next = IDLE;
        endcase
        if (m_valid) begin
            m_data  = tile_buf[rd_bank][beat_c][beat_r*RW +: RW];
            m_last  = last_beat;
            beat_hs = m_ready;
            if (beat_hs && last_beat)
                state_next = full[~rd_bank] ? STREAM : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            tile_col <= '0;
            beat_r   <= '0;
            beat_c   <= '0;
            band     <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (tile_valid && !tile_ready)
                overflow <= 1'b1;
            if (accept) begin
                if (tile_col == COL_LAST) begin
                    tile_col      <= '0;
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end else begin
                    tile_col <= tile_col + 1'b1;
                end
            end
            if (beat_hs) begin
                if (beat_c == COL_LAST) begin
                    beat_c <= '0;
                    beat_r <= (beat_r == ROW_LAST) ? '0 : beat_r + 1'b1;
                end else begin
                    beat_c <= beat_c + 1'b1;
                end
                // Capture only ever targets the other bank here, so set and clear never collide.
                if (last_beat) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    if (band == BAND_LAST) begin
                        band <= '0;
                        done <= 1'b1;
                    end else begin
                        band <= band + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            tile_buf[wr_bank][tile_col] <= tile_data;
    end

endmodule

// File: tb/tb_tile_row_collector.sv
// tb/tb_tile_row_collector.sv - scoreboard bench for tile_row_collector
module tb_tile_row_collector;

    localparam int W = 16, B = 2, CH = 4, ROWS = 3, COLS = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tile_valid = 1'b0;
    logic              tile_ready;
    logic [W*CH-1:0]   tile_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [W*B-1:0]    m_data;
    logic              m_last;
    logic              done;
    logic              overflow;

    tile_row_collector #(.WIDTH(W), .BLOCK_SIZE(B), .CHUNK_SIZE(CH),
                         .ROW_SIZE_MAT_C(ROWS), .COL_SIZE_MAT_C(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_data(tile_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit in_reset = 1'b1;
    int ready_mode = 1;            // 0 stall, 1 always ready, 2 random

    // Reference model: a band of COLS tiles is emitted row by row across the tiles;
    // at most two complete bands can be held before new tiles are refused.
    logic [W*CH-1:0] part_q[$];
    logic [W*B:0]    exp_q[$];     // {last, segment}
    int completed = 0, completed_next = 0, drained = 0, band_ctr = 0;
    bit ovf_model = 1'b0, done_due = 1'b0;
    int done_seen = 0;

    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0: m_ready = 1'b0;
            1: m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(1, 0));
        endcase
    end

    // Input-side model
    initial forever begin
        @(negedge clk);
        if (!in_reset) begin
            bit exp_ready;
            completed = completed_next;
            exp_ready = (completed - drained) < 2;
            checks++;
            if (tile_ready !== exp_ready) begin
                errors++;
                $display("FAIL tile_ready: got %b expected %b at %0t", tile_ready, exp_ready, $time);
            end
            checks++;
            if (overflow !== ovf_model) begin
                errors++;
                $display("FAIL overflow: got %b expected %b at %0t", overflow, ovf_model, $time);
            end
            if (tile_valid) begin
                if (exp_ready) begin
                    part_q.push_back(tile_data);
                    if (part_q.size() == COLS) begin
                        for (int r = 0; r < B; r++)
                            for (int c = 0; c < COLS; c++) begin
                                logic [W*CH-1:0] t;
                                t = part_q[c];
                                exp_q.push_back({(r == B-1 && c == COLS-1), t[r*W*B +: W*B]});
                            end
                        part_q.delete();
                        completed_next++;
                    end
                end else begin
                    ovf_model = 1'b1;
                end
            end
        end
    end

    // Output-side monitor
    bit              prev_stall = 1'b0;
    logic [W*B-1:0]  prev_data;
    bit              prev_last;

    initial forever begin
        @(negedge clk); #1;
        if (in_reset) begin
            prev_stall = 1'b0;
        end else begin
            bit exp_valid;
            checks++;
            if (done !== done_due) begin
                errors++;
                $display("FAIL done: got %b expected %b at %0t", done, done_due, $time);
            end
            if (done === 1'b1) done_seen++;
            done_due = 1'b0;
            exp_valid = (completed - drained) > 0;
            checks++;
            if (m_valid !== exp_valid) begin
                errors++;
                $display("FAIL m_valid: got %b expected %b at %0t", m_valid, exp_valid, $time);
            end
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b at %0t",
                             m_valid, m_data, m_last, prev_data, prev_last, $time);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: got unexpected d=%h expected no beat at %0t", m_data, $time);
                end else begin
                    logic [W*B:0] e;
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        errors++;
                        $display("FAIL beat: got l=%b d=%h expected l=%b d=%h at %0t",
                                 m_last, m_data, e[W*B], e[W*B-1:0], $time);
                    end
                    if (e[W*B]) begin
                        drained++;
                        band_ctr++;
                        if (band_ctr == ROWS) begin
                            band_ctr = 0;
                            done_due = 1'b1;
                        end
                    end
                end
            end
            prev_stall = (m_valid === 1'b1) && (m_ready !== 1'b1);
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        rst_n = 1'b0;
        tile_valid = 1'b0;
        @(posedge clk); #1;
        part_q.delete();
        exp_q.delete();
        completed = 0; completed_next = 0; drained = 0; band_ctr = 0;
        ovf_model = 1'b0; done_due = 1'b0;
        @(negedge clk);
        check_val("rst_tile_ready", 64'(tile_ready), 64'd1);
        check_val("rst_m_valid", 64'(m_valid), 64'd0);
        check_val("rst_m_data", 64'(m_data), 64'd0);
        check_val("rst_m_last", 64'(m_last), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_reset = 1'b0;
    endtask

    // polite=1 waits for tile_ready before presenting; polite=0 ignores it
    task automatic send_tile(input logic [W*CH-1:0] d, input bit polite);
        int guard = 0;
        while (polite && !tile_ready && guard < 200) begin
            tile_valid = 1'b0;
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            errors++;
            $display("FAIL ready_timeout: got tile_ready 0 expected 1 within 200 cycles");
        end
        tile_valid = 1'b1;
        tile_data = d;
        @(posedge clk); #1;
        tile_valid = 1'b0;
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++)
            send_tile({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)}, 1'b1);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || completed_next != drained) && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2000) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_done_count(input string name, input int exp);
        checks++;
        if (done_seen != exp) begin
            errors++;
            $display("FAIL %s: got %0d done pulses expected %0d", name, done_seen, exp);
        end
    endtask

    initial begin
        int d0;
        do_reset();

        // single band, known values
        ready_mode = 1;
        for (int t = 0; t < 3; t++)
            send_tile({16'(4*t+4), 16'(4*t+3), 16'(4*t+2), 16'(4*t+1)}, 1'b0);
        wait_drain();
        check_done_count("single_band_done", 0);

        // full matrix then a second matrix without reset
        do_reset();
        d0 = done_seen;
        send_random(9);
        wait_drain();
        check_done_count("matrix1_done", d0 + 1);
        ready_mode = 2;
        send_random(9);
        wait_drain();
        check_done_count("matrix2_done", d0 + 2);

        // backpressure: 7 tiles with consumer stalled
        do_reset();
        ready_mode = 0;
        for (int t = 0; t < 7; t++)
            send_tile({16'(4*t+4), 16'(4*t+3), 16'(4*t+2), 16'(4*t+1)}, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("bp_overflow", 64'(overflow), 64'd1);
        check_val("bp_tile_ready", 64'(tile_ready), 64'd0);
        check_val("bp_head_data", 64'(m_data), 64'h0002_0001);
        @(posedge clk); #1;
        ready_mode = 1;
        wait_drain();

        // reset mid-band, then a fresh band
        do_reset();
        send_random(2);
        d0 = done_seen;
        do_reset();
        send_random(3);
        wait_drain();
        check_done_count("after_midband_reset_done", d0);

        // random backpressure over a full matrix
        do_reset();
        ready_mode = 2;
        d0 = done_seen;
        send_random(9);
        wait_drain();
        check_done_count("random_ready_done", d0 + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
